// File: rtl/ddr2_cmd_scheduler.sv
// ddr2_cmd_scheduler: DDR2 command-bus front end. Accepts single read/write
// requests, tracks the open row of every bank and drives ACT/PRE/RD/WR/REF
// on a registered command bus with the required inter-command spacing.
//
// Timing counters hold "cycles remaining minus one": a counter loaded when
// command X goes onto the bus lets the dependent command Y be selected in the
// cycle the counter reads zero, so Y reaches the registered bus exactly T
// cycles after X.
module ddr2_cmd_scheduler #(
  parameter int BA_WIDTH  = 3,
  parameter int ROW_WIDTH = 14,
  parameter int COL_WIDTH = 10,
  parameter int T_RCD     = 4,
  parameter int T_RP      = 4,
  parameter int T_RAS     = 12,
  parameter int T_WPR     = 8,
  parameter int T_CCD     = 2,
  parameter int T_RTW     = 4,
  parameter int T_WTR     = 6,
  parameter int T_RFC     = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BA_WIDTH-1:0]  req_ba,
  input  logic [ROW_WIDTH-1:0] req_row,
  input  logic [COL_WIDTH-1:0] req_col,
  input  logic                 ref_req,
  output logic                 ref_ack,
  output logic                 rd_issue,
  output logic                 wr_issue,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 ras_n,
  output logic                 cas_n,
  output logic                 we_n,
  output logic [BA_WIDTH-1:0]  ba,
  output logic [ROW_WIDTH-1:0] addr
);

  localparam int NUM_BANKS = 1 << BA_WIDTH;
  localparam int CNT_W     = $clog2(T_RFC + 1);
  localparam int A10       = 10;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // ACT->column goes through the COL state, which costs one extra cycle.
  localparam logic [CNT_W-1:0] LD_RCD   = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] LD_RP    = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_RAS   = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] LD_WPR   = CNT_W'(T_WPR - 1);
  localparam logic [CNT_W-1:0] LD_CCD   = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] LD_RTW   = CNT_W'(T_RTW - 1);
  localparam logic [CNT_W-1:0] LD_WTR   = CNT_W'(T_WTR - 1);
  localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(T_RFC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE_WAIT, ST_ACT_WAIT, ST_COL, ST_REF_PRE, ST_REF_RP, ST_REF_WAIT
  } state_t;

  typedef enum logic [2:0] {
    CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_PREA, CMD_REF
  } cmd_t;

  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    if (v == CNT_ZERO) begin
      return CNT_ZERO;
    end else begin
      return v - CNT_ONE;
    end
  endfunction

  function automatic logic [CNT_W-1:0] max_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  // FSM, latched request and refresh bookkeeping
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       wait_q, wait_d;
  logic                   pre_done_q, pre_done_d;
  logic                   lat_wr_q, lat_wr_d;
  logic [BA_WIDTH-1:0]    lat_ba_q, lat_ba_d;
  logic [ROW_WIDTH-1:0]   lat_row_q, lat_row_d;
  logic [COL_WIDTH-1:0]   lat_col_q, lat_col_d;
  logic                   ref_pend_q, ref_pend_d;

  // Bank table and timing counters
  logic [NUM_BANKS-1:0]   open_q, open_d;
  logic [ROW_WIDTH-1:0]   row_q   [NUM_BANKS];
  logic [ROW_WIDTH-1:0]   row_d   [NUM_BANKS];
  logic [CNT_W-1:0]       prech_q [NUM_BANKS];
  logic [CNT_W-1:0]       prech_d [NUM_BANKS];
  logic [CNT_W-1:0]       rd_gap_q, rd_gap_d;
  logic [CNT_W-1:0]       wr_gap_q, wr_gap_d;

  // Registered outputs
  logic                   req_ready_q, req_ready_d;
  logic                   ref_ack_q, ref_ack_d;
  logic                   rd_issue_q, rd_issue_d;
  logic                   wr_issue_q, wr_issue_d;
  logic                   cke_q, cke_d;
  logic                   cs_n_q, cs_n_d;
  logic                   ras_n_q, ras_n_d;
  logic                   cas_n_q, cas_n_d;
  logic                   we_n_q, we_n_d;
  logic [BA_WIDTH-1:0]    ba_q, ba_d;
  logic [ROW_WIDTH-1:0]   addr_q, addr_d;

  // Combinational helpers
  cmd_t                   cmd_s;
  logic [BA_WIDTH-1:0]    cmd_ba_s;
  logic [ROW_WIDTH-1:0]   cmd_row_s;
  logic                   ref_done_s;
  logic                   prech_idle_s;
  logic                   col_ok_s;

  // All banks have satisfied tRAS/tWR and may take a PRE-all
  always_comb begin
    prech_idle_s = 1'b1;
    for (int i = 0; i < NUM_BANKS; i++) begin
      prech_idle_s = prech_idle_s & (prech_q[i] == CNT_ZERO);
    end
  end

  // Column spacing is tracked per direction so RD->RD, RD->WR and WR->RD each get their own gap
  always_comb begin
    if (lat_wr_q) begin
      col_ok_s = (wr_gap_q == CNT_ZERO);
    end else begin
      col_ok_s = (rd_gap_q == CNT_ZERO);
    end
  end

  // Next-state logic and selection of the command to place on the bus
  always_comb begin
    state_d    = state_q;
    wait_d     = dec_sat(wait_q);
    pre_done_d = pre_done_q;
    lat_wr_d   = lat_wr_q;
    lat_ba_d   = lat_ba_q;
    lat_row_d  = lat_row_q;
    lat_col_d  = lat_col_q;
    cmd_s      = CMD_NOP;
    cmd_ba_s   = lat_ba_q;
    cmd_row_s  = lat_row_q;
    ref_done_s = 1'b0;
    ref_ack_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          lat_wr_d  = req_wr;
          lat_ba_d  = req_ba;
          lat_row_d = req_row;
          lat_col_d = req_col;
          cmd_ba_s  = req_ba;
          cmd_row_s = req_row;
          if (open_q[req_ba] && (row_q[req_ba] == req_row)) begin
            state_d = ST_COL;
          end else if (!open_q[req_ba]) begin
            cmd_s   = CMD_ACT;
            wait_d  = LD_RCD;
            state_d = ST_ACT_WAIT;
          end else if (prech_q[req_ba] == CNT_ZERO) begin
            cmd_s      = CMD_PRE;
            wait_d     = LD_RP;
            pre_done_d = 1'b1;
            state_d    = ST_PRE_WAIT;
          end else begin
            pre_done_d = 1'b0;
            state_d    = ST_PRE_WAIT;
          end
        end else if (ref_pend_q) begin
          if (|open_q) begin
            state_d = ST_REF_PRE;
          end else begin
            cmd_s   = CMD_REF;
            wait_d  = LD_RFC;
            state_d = ST_REF_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRE_WAIT: begin
        if (!pre_done_q) begin
          if (prech_q[lat_ba_q] == CNT_ZERO) begin
            cmd_s      = CMD_PRE;
            wait_d     = LD_RP;
            pre_done_d = 1'b1;
          end else begin
            pre_done_d = 1'b0;
          end
        end else if (wait_q == CNT_ZERO) begin
          cmd_s   = CMD_ACT;
          wait_d  = LD_RCD;
          state_d = ST_ACT_WAIT;
        end else begin
          state_d = ST_PRE_WAIT;
        end
      end
      ST_ACT_WAIT: begin
        if (wait_q == CNT_ZERO) begin
          state_d = ST_COL;
        end else begin
          state_d = ST_ACT_WAIT;
        end
      end
      ST_COL: begin
        if (col_ok_s) begin
          cmd_s   = lat_wr_q ? CMD_WR : CMD_RD;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COL;
        end
      end
      ST_REF_PRE: begin
        if (prech_idle_s) begin
          cmd_s   = CMD_PREA;
          wait_d  = LD_RP;
          state_d = ST_REF_RP;
        end else begin
          state_d = ST_REF_PRE;
        end
      end
      ST_REF_RP: begin
        if (wait_q == CNT_ZERO) begin
          cmd_s   = CMD_REF;
          wait_d  = LD_RFC;
          state_d = ST_REF_WAIT;
        end else begin
          state_d = ST_REF_RP;
        end
      end
      ST_REF_WAIT: begin
        if (wait_q == CNT_ZERO) begin
          ref_done_s = 1'b1;
          ref_ack_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_REF_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Refresh requests collapse into one pending flag; those seen during REF_WAIT are absorbed
    if (cmd_s == CMD_REF) begin
      ref_pend_d = 1'b0;
    end else if (ref_req && (state_q != ST_REF_WAIT)) begin
      ref_pend_d = 1'b1;
    end else begin
      ref_pend_d = ref_pend_q;
    end

    req_ready_d = (state_d == ST_IDLE) && !ref_pend_d;
  end

  // Bank open/row table and timing counter updates driven by the selected command
  always_comb begin
    open_d   = open_q;
    rd_gap_d = dec_sat(rd_gap_q);
    wr_gap_d = dec_sat(wr_gap_q);
    for (int i = 0; i < NUM_BANKS; i++) begin
      row_d[i]   = row_q[i];
      prech_d[i] = dec_sat(prech_q[i]);
    end
    case (cmd_s)
      CMD_ACT: begin
        open_d[cmd_ba_s]  = 1'b1;
        row_d[cmd_ba_s]   = cmd_row_s;
        prech_d[cmd_ba_s] = LD_RAS;
      end
      CMD_PRE: begin
        open_d[cmd_ba_s] = 1'b0;
      end
      CMD_PREA: begin
        open_d = {NUM_BANKS{1'b0}};
      end
      CMD_RD: begin
        rd_gap_d = LD_CCD;
        wr_gap_d = LD_RTW;
      end
      CMD_WR: begin
        wr_gap_d          = LD_CCD;
        rd_gap_d          = LD_WTR;
        prech_d[cmd_ba_s] = max_cnt(dec_sat(prech_q[cmd_ba_s]), LD_WPR);
      end
      default: begin
        open_d = open_d;
      end
    endcase
    if (ref_done_s) begin
      open_d = {NUM_BANKS{1'b0}};
    end else begin
      open_d = open_d;
    end
  end

  // Command pin encoding (cs,ras,cas,we) and address/bank mux for the registered bus
  always_comb begin
    cke_d      = 1'b1;
    cs_n_d     = 1'b0;
    ras_n_d    = 1'b1;
    cas_n_d    = 1'b1;
    we_n_d     = 1'b1;
    ba_d       = BA_WIDTH'(0);
    addr_d     = ROW_WIDTH'(0);
    rd_issue_d = 1'b0;
    wr_issue_d = 1'b0;
    case (cmd_s)
      CMD_ACT: begin
        {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0011;
        ba_d   = cmd_ba_s;
        addr_d = cmd_row_s;
      end
      CMD_RD: begin
        {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0101;
        ba_d                   = cmd_ba_s;
        addr_d[COL_WIDTH-1:0]  = lat_col_q;
        addr_d[A10]            = 1'b0;
        rd_issue_d             = 1'b1;
      end
      CMD_WR: begin
        {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0100;
        ba_d                   = cmd_ba_s;
        addr_d[COL_WIDTH-1:0]  = lat_col_q;
        addr_d[A10]            = 1'b0;
        wr_issue_d             = 1'b1;
      end
      CMD_PRE: begin
        {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0010;
        ba_d = cmd_ba_s;
      end
      CMD_PREA: begin
        {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0010;
        addr_d[A10] = 1'b1;
      end
      CMD_REF: begin
        {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0001;
      end
      default: begin
        {cs_n_d, ras_n_d, cas_n_d, we_n_d} = 4'b0111;
      end
    endcase
  end

  // State, bank table, counters and bus registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= CNT_ZERO;
      pre_done_q  <= 1'b0;
      lat_wr_q    <= 1'b0;
      lat_ba_q    <= BA_WIDTH'(0);
      lat_row_q   <= ROW_WIDTH'(0);
      lat_col_q   <= COL_WIDTH'(0);
      ref_pend_q  <= 1'b0;
      open_q      <= {NUM_BANKS{1'b0}};
      for (int i = 0; i < NUM_BANKS; i++) begin
        row_q[i]   <= ROW_WIDTH'(0);
        prech_q[i] <= CNT_ZERO;
      end
      rd_gap_q    <= CNT_ZERO;
      wr_gap_q    <= CNT_ZERO;
      req_ready_q <= 1'b0;
      ref_ack_q   <= 1'b0;
      rd_issue_q  <= 1'b0;
      wr_issue_q  <= 1'b0;
      cke_q       <= 1'b0;
      cs_n_q      <= 1'b1;
      ras_n_q     <= 1'b1;
      cas_n_q     <= 1'b1;
      we_n_q      <= 1'b1;
      ba_q        <= BA_WIDTH'(0);
      addr_q      <= ROW_WIDTH'(0);
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      pre_done_q  <= pre_done_d;
      lat_wr_q    <= lat_wr_d;
      lat_ba_q    <= lat_ba_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      ref_pend_q  <= ref_pend_d;
      open_q      <= open_d;
      for (int i = 0; i < NUM_BANKS; i++) begin
        row_q[i]   <= row_d[i];
        prech_q[i] <= prech_d[i];
      end
      rd_gap_q    <= rd_gap_d;
      wr_gap_q    <= wr_gap_d;
      req_ready_q <= req_ready_d;
      ref_ack_q   <= ref_ack_d;
      rd_issue_q  <= rd_issue_d;
      wr_issue_q  <= wr_issue_d;
      cke_q       <= cke_d;
      cs_n_q      <= cs_n_d;
      ras_n_q     <= ras_n_d;
      cas_n_q     <= cas_n_d;
      we_n_q      <= we_n_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
    end
  end

  assign req_ready = req_ready_q;
  assign ref_ack   = ref_ack_q;
  assign rd_issue  = rd_issue_q;
  assign wr_issue  = wr_issue_q;
  assign cke       = cke_q;
  assign cs_n      = cs_n_q;
  assign ras_n     = ras_n_q;
  assign cas_n     = cas_n_q;
  assign we_n      = we_n_q;
  assign ba        = ba_q;
  assign addr      = addr_q;

endmodule

// File: tb/tb_ddr2_cmd_scheduler.sv
// tb_ddr2_cmd_scheduler: directed bench for the DDR2 command scheduler.
// A negedge monitor logs every non-NOP bus command with its cycle number;
// the directed steps then compare the log against hand-computed timings.
module tb_ddr2_cmd_scheduler;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_ba;
  logic [13:0] req_row;
  logic [9:0]  req_col;
  logic        ref_req, ref_ack, rd_issue, wr_issue;
  logic        cke, cs_n, ras_n, cas_n, we_n;
  logic [2:0]  ba;
  logic [13:0] addr;
  logic [3:0]  bus_code;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  code;
    logic [2:0]  ba;
    logic [13:0] addr;
    logic        rdi;
    logic        wri;
  } ent_t;

  ent_t log_q[$];
  int   ack_q[$];

  ddr2_cmd_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req), .ref_ack(ref_ack),
    .rd_issue(rd_issue), .wr_issue(wr_issue),
    .cke(cke), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr)
  );

  assign bus_code = {cs_n, ras_n, cas_n, we_n};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && !cs_n && bus_code != C_NOP)
      log_q.push_back('{cyc, bus_code, ba, addr, rd_issue, wr_issue});
    if (ref_ack)
      ack_q.push_back(cyc);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request from a negedge and hold it until accepted.
  task automatic send(input logic wr, input logic [2:0] b, input logic [13:0] r,
                      input logic [9:0] c);
    int k = 0;
    req_valid = 1'b1; req_wr = wr; req_ba = b; req_row = r; req_col = c;
    while (req_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("send_timeout", 32'(k), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_ba = 3'd0;
    req_row = 14'd0; req_col = 10'd0; ref_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({cke, cs_n, ras_n, cas_n, we_n, req_ready, ref_ack, rd_issue, wr_issue}),
          32'b0_1111_0000);
    check("rst_ba", 32'(ba), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("exit_cke", 32'(cke), 32'd1);
    check("exit_nop", 32'(bus_code), 32'(C_NOP));
    check("exit_ready", 32'(req_ready), 32'd1);

    // 1: read to closed bank 2
    log_q.delete();
    send(1'b0, 3'd2, 14'h123, 10'h040);
    wait_log(2, "t1_wait");
    check("t1_act_code", 32'(log_q[0].code), 32'(C_ACT));
    check("t1_act_ba", 32'(log_q[0].ba), 32'd2);
    check("t1_act_addr", 32'(log_q[0].addr), 32'h123);
    check("t1_rd_code", 32'(log_q[1].code), 32'(C_RD));
    check("t1_rd_addr", 32'(log_q[1].addr), 32'h040);
    check("t1_rd_ba", 32'(log_q[1].ba), 32'd2);
    check("t1_trcd", log_q[1].cyc - log_q[0].cyc, 32'd4);
    check("t1_rd_issue", 32'(log_q[1].rdi), 32'd1);

    // 2: back-to-back row hits
    log_q.delete();
    send(1'b0, 3'd2, 14'h123, 10'h000);
    send(1'b0, 3'd2, 14'h123, 10'h008);
    wait_log(2, "t2_wait");
    repeat (10) @(negedge clk);
    check("t2_count", 32'(log_q.size()), 32'd2);
    check("t2_code0", 32'(log_q[0].code), 32'(C_RD));
    check("t2_code1", 32'(log_q[1].code), 32'(C_RD));
    check("t2_addr1", 32'(log_q[1].addr), 32'h008);
    check("t2_tccd", log_q[1].cyc - log_q[0].cyc, 32'd2);

    // 3: row miss bounded by tRAS
    log_q.delete();
    send(1'b0, 3'd1, 14'h005, 10'h000);
    send(1'b0, 3'd1, 14'h006, 10'h003);
    wait_log(5, "t3_wait");
    check("t3_pre_code", 32'(log_q[2].code), 32'(C_PRE));
    check("t3_pre_a10", 32'(log_q[2].addr[10]), 32'd0);
    check("t3_pre_ba", 32'(log_q[2].ba), 32'd1);
    check("t3_tras", log_q[2].cyc - log_q[0].cyc, 32'd12);
    check("t3_act_addr", 32'(log_q[3].addr), 32'h006);
    check("t3_act_t", log_q[3].cyc - log_q[0].cyc, 32'd16);
    check("t3_rd_code", 32'(log_q[4].code), 32'(C_RD));
    check("t3_rd_t", log_q[4].cyc - log_q[0].cyc, 32'd20);

    // 4: write, read-after-write, then miss bounded by write recovery
    log_q.delete();
    send(1'b1, 3'd0, 14'h010, 10'h020);
    send(1'b0, 3'd0, 14'h010, 10'h028);
    send(1'b0, 3'd0, 14'h011, 10'h000);
    wait_log(6, "t4_wait");
    check("t4_wr_code", 32'(log_q[1].code), 32'(C_WR));
    check("t4_wr_issue", 32'(log_q[1].wri), 32'd1);
    check("t4_wr_addr", 32'(log_q[1].addr), 32'h020);
    check("t4_rd_code", 32'(log_q[2].code), 32'(C_RD));
    check("t4_twtr", log_q[2].cyc - log_q[1].cyc, 32'd6);
    check("t4_pre_code", 32'(log_q[3].code), 32'(C_PRE));
    check("t4_twpr", log_q[3].cyc - log_q[1].cyc, 32'd8);

    // 5: refresh with open banks, plus a merged second request
    send(1'b0, 3'd3, 14'h007, 10'h000);
    repeat (30) @(negedge clk);
    log_q.delete();
    ack_q.delete();
    ref_req = 1'b1;
    @(negedge clk);
    ref_req = 1'b0;
    check("t5_ready_low", 32'(req_ready), 32'd0);
    wait_log(2, "t5_wait_ref");
    ref_req = 1'b1;
    @(negedge clk);
    ref_req = 1'b0;
    check("t5_prea_code", 32'(log_q[0].code), 32'(C_PRE));
    check("t5_prea_a10", 32'(log_q[0].addr[10]), 32'd1);
    check("t5_ref_code", 32'(log_q[1].code), 32'(C_REF));
    check("t5_trp", log_q[1].cyc - log_q[0].cyc, 32'd4);
    k = 0;
    while (ack_q.size() < 1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_ack_seen", 32'(ack_q.size()), 32'd1);
    check("t5_trfc", 32'(ack_q[0]) - log_q[1].cyc, 32'd26);
    send(1'b0, 3'd0, 14'h011, 10'h000);
    wait_log(4, "t5_wait_act");
    check("t5_act_code", 32'(log_q[2].code), 32'(C_ACT));
    check("t5_act_ba", 32'(log_q[2].ba), 32'd0);
    check("t5_act_addr", 32'(log_q[2].addr), 32'h011);
    repeat (40) @(negedge clk);
    check("t5_single_ref", 32'(log_q.size()), 32'd4);

    // 6: reset during ACT_WAIT
    send(1'b0, 3'd5, 14'h055, 10'h000);
    rst_n = 1'b0;
    #1;
    check("t6_rst_cke", 32'(cke), 32'd0);
    check("t6_rst_csn", 32'(cs_n), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_exit_cke", 32'(cke), 32'd1);
    check("t6_exit_nop", 32'(bus_code), 32'(C_NOP));
    log_q.delete();
    repeat (20) @(negedge clk);
    check("t6_dropped", 32'(log_q.size()), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
